cp0_regfile: RTL and testbench



---
 rtl/cp0_regfile.sv | 178 +++++++++++++++++
 tb/tb_cp0_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cp0_regfile
// Purpose  : MIPS-style coprocessor-0 register file with Count/Compare timer,
//            interrupt pending logic and exception/eret bookkeeping.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_regfile #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] PRID_VALUE   = 32'h004C0102,
    parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           badvaddr_o,
    output logic [31:0]           count_o,
    output logic                  timer_int_o,
    output logic                  int_req_o
);

    localparam logic [4:0]  c_REG_BADVADDR = 5'd8;
    localparam logic [4:0]  c_REG_COUNT    = 5'd9;
    localparam logic [4:0]  c_REG_COMPARE  = 5'd11;
    localparam logic [4:0]  c_REG_STATUS   = 5'd12;
    localparam logic [4:0]  c_REG_CAUSE    = 5'd13;
    localparam logic [4:0]  c_REG_EPC      = 5'd14;
    localparam logic [4:0]  c_REG_PRID     = 5'd15;
    localparam logic [4:0]  c_REG_CONFIG   = 5'd16;
    localparam logic [31:0] c_CONFIG       = 32'h00008000;
    localparam logic [31:0] c_STATUS_WMASK = 32'h0000FF03;
    localparam logic        c_PS_LAST      = 1'(COUNT_DIV - 1);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_status;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_prescale;
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;

    logic [5:0]  w_hw_ext;
    logic        w_tick;
    logic        w_we_count;
    logic        w_we_compare;
    logic        w_we_status;
    logic        w_we_cause;
    logic        w_exl;
    logic [31:0] w_status_next;
    logic [31:0] w_cause;

    // Unused hardware interrupt positions are tied low.
    generate
        if (NUM_HW_INT >= 6) begin : g_hw_full
            assign w_hw_ext = hw_int_i[5:0];
        end else begin : g_hw_pad
            assign w_hw_ext = {{(6 - NUM_HW_INT){1'b0}}, hw_int_i};
        end
    endgenerate

    assign w_tick       = (r_prescale == c_PS_LAST);
    assign w_we_count   = we_i && (waddr_i == c_REG_COUNT);
    assign w_we_compare = we_i && (waddr_i == c_REG_COMPARE);
    assign w_we_status  = we_i && (waddr_i == c_REG_STATUS);
    assign w_we_cause   = we_i && (waddr_i == c_REG_CAUSE);
    assign w_exl        = r_status[1];

    // Exception and eret own EXL; mtc0 still lands on IM/IE in the same cycle.
    always_comb begin
        w_status_next = r_status;
        if (w_we_status) begin
            w_status_next = (STATUS_RESET & ~c_STATUS_WMASK) | (data_i & c_STATUS_WMASK);
        end
        if (exc_valid_i) begin
            w_status_next[1] = 1'b1;
        end else if (eret_i) begin
            w_status_next[1] = 1'b0;
        end
    end

    assign w_cause = {r_bd, r_ti, 14'b0, r_ip_hw[5] | r_ti, r_ip_hw[4:0],
                      r_ip_sw, 1'b0, r_exccode, 2'b00};

    always_ff @(negedge clk) begin
        if (rst) begin
            r_count    <= 32'd0;
            r_compare  <= 32'd0;
            r_status   <= STATUS_RESET;
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
            r_prescale <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
        end else begin
            if (w_we_count) begin
                r_count    <= data_i;
                r_prescale <= 1'b0;
            end else if (w_tick) begin
                r_count    <= r_count + 32'd1;
                r_prescale <= 1'b0;
            end else begin
                r_prescale <= r_prescale + 1'b1;
            end

            if (w_we_compare) begin
                r_compare <= data_i;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end

            r_status <= w_status_next;
            r_ip_hw  <= w_hw_ext;

            if (w_we_cause) begin
                r_ip_sw <= data_i[9:8];
            end

            if (exc_valid_i) begin
                r_exccode <= exc_code_i;
                if (!w_exl) begin
                    r_epc <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                    r_bd  <= exc_bd_i;
                end
                if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)) begin
                    r_badvaddr <= exc_badvaddr_i;
                end
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            c_REG_BADVADDR: data_o = r_badvaddr;
            c_REG_COUNT:    data_o = r_count;
            c_REG_COMPARE:  data_o = r_compare;
            c_REG_STATUS:   data_o = r_status;
            c_REG_CAUSE:    data_o = w_cause;
            c_REG_EPC:      data_o = r_epc;
            c_REG_PRID:     data_o = PRID_VALUE;
            c_REG_CONFIG:   data_o = c_CONFIG;
            default:        data_o = 32'd0;
        endcase
    end

    assign status_o    = r_status;
    assign cause_o     = w_cause;
    assign epc_o       = r_epc;
    assign badvaddr_o  = r_badvaddr;
    assign count_o     = r_count;
    assign timer_int_o = r_ti;
    assign int_req_o   = r_status[0] & ~w_exl & (|(w_cause[15:8] & r_status[15:8]));

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_regfile
// Purpose  : Directed self-checking bench for cp0_regfile (default instance A,
//            plus instance B with COUNT_DIV=1 and NUM_HW_INT=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  hw_a;
    logic [1:0]  hw_b;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_i;

    logic [31:0] a_data, a_status, a_cause, a_epc, a_badv, a_count;
    logic        a_ti, a_irq;
    logic [31:0] b_data, b_status, b_cause, b_epc, b_badv, b_count;
    logic        b_ti, b_irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_regfile u_dut_a (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .hw_int_i(hw_a), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
        .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i), .data_o(a_data),
        .status_o(a_status), .cause_o(a_cause), .epc_o(a_epc),
        .badvaddr_o(a_badv), .count_o(a_count), .timer_int_o(a_ti),
        .int_req_o(a_irq)
    );

    cp0_regfile #(.NUM_HW_INT(2), .COUNT_DIV(1)) u_dut_b (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
        .data_i(data_i), .hw_int_i(hw_b), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
        .exc_badvaddr_i(exc_badvaddr_i), .eret_i(eret_i), .data_o(b_data),
        .status_o(b_status), .cause_o(b_cause), .epc_o(b_epc),
        .badvaddr_o(b_badv), .count_o(b_count), .timer_int_o(b_ti),
        .int_req_o(b_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // State updates on the falling edge; sample 1 time unit later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
        we_i = 1'b1; waddr_i = addr; data_i = val;
        tick();
        we_i = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic bd,
                       input logic [31:0] pc, input logic [31:0] badv);
        exc_valid_i = 1'b1; exc_code_i = code; exc_bd_i = bd;
        exc_pc_i = pc; exc_badvaddr_i = badv;
        tick();
        exc_valid_i = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd15; data_i = '0;
        hw_a = '0; hw_b = '0; exc_valid_i = 1'b0; exc_code_i = '0;
        exc_pc_i = '0; exc_bd_i = 1'b0; exc_badvaddr_i = '0; eret_i = 1'b0;
        repeat (3) tick();

        check("rst_status", a_status, 32'h10000000);
        check("rst_cause", a_cause, 32'h0);
        check("rst_count", a_count, 32'h0);
        check("rst_epc", a_epc, 32'h0);
        check("rst_badv", a_badv, 32'h0);
        check("rst_ti_irq", {30'b0, a_ti, a_irq}, 32'h0);
        check("rd_prid", a_data, 32'h004C0102);

        // Timer: Compare=10 written on the first active edge after reset.
        rst = 1'b0;
        mtc0(5'd11, 32'd10);
        check("ti_clr_first", {31'b0, a_ti}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (a_ti) begin
                seen = 1'b1;
                break;
            end
        end
        check("ti_rise", {31'b0, seen}, 32'h1);
        check("ti_count", a_count, 32'd10);
        check("ti_cause", a_cause, 32'h40008000);
        check("irq_masked", {31'b0, a_irq}, 32'h0);
        mtc0(5'd12, 32'h00008001);
        check("status_wr", a_status, 32'h10008001);
        check("irq_timer", {31'b0, a_irq}, 32'h1);
        mtc0(5'd11, 32'hFFFF0000);
        check("ti_cleared", {31'b0, a_ti}, 32'h0);
        check("irq_cleared", {31'b0, a_irq}, 32'h0);

        // First exception in a delay slot, address error.
        exc(5'd4, 1'b1, 32'h80000104, 32'h00001233);
        check("exc1_epc", a_epc, 32'h80000100);
        check("exc1_cause", a_cause, 32'h80000010);
        check("exc1_badv", a_badv, 32'h00001233);
        check("exc1_status", a_status, 32'h10008003);

        // Nested exception while EXL=1, then eret.
        exc(5'd8, 1'b0, 32'h12345678, 32'h0000BEEF);
        check("exc2_epc", a_epc, 32'h80000100);
        check("exc2_cause", a_cause, 32'h80000020);
        check("exc2_badv", a_badv, 32'h00001233);
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
        check("eret_status", a_status, 32'h10008001);

        // Exception and mtc0 Status in the same cycle.
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        exc(5'd12, 1'b0, 32'h00000400, 32'h0000DEAD);
        we_i = 1'b0;
        check("exc_mtc0_status", a_status, 32'h10000002);
        check("exc3_epc", a_epc, 32'h00000400);
        check("exc3_cause", a_cause, 32'h00000030);

        // eret and mtc0 Status together: eret owns EXL, IM/IE still written.
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000FF03; eret_i = 1'b1;
        tick();
        we_i = 1'b0; eret_i = 1'b0;
        check("eret_mtc0_status", a_status, 32'h1000FF01);

        mtc0(5'd13, 32'hFFFFFFFF);
        check("cause_wmask", a_cause, 32'h00000330);
        check("irq_sw", {31'b0, a_irq}, 32'h1);
        mtc0(5'd13, 32'h0);
        check("irq_sw_off", {31'b0, a_irq}, 32'h0);

        mtc0(5'd8, 32'h0000FFFF);
        mtc0(5'd15, 32'h0);
        check("badv_ro", a_badv, 32'h00001233);
        raddr_i = 5'd15; #1 check("rd_prid_ro", a_data, 32'h004C0102);
        raddr_i = 5'd16; #1 check("rd_config", a_data, 32'h00008000);
        raddr_i = 5'd31; #1 check("rd_unlisted", a_data, 32'h0);
        raddr_i = 5'd14; #1 check("rd_epc", a_data, 32'h00000400);

        // No write bypass on the read port.
        raddr_i = 5'd12; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000F001;
        #1 check("rd_no_bypass", a_data, 32'h1000FF01);
        tick();
        we_i = 1'b0;
        check("rd_after_wr", a_data, 32'h1000F001);
        mtc0(5'd12, 32'h0000FF01);

        // Count wrap (B: COUNT_DIV=1) and prescaler clear (A: COUNT_DIV=2).
        mtc0(5'd9, 32'hFFFFFFFF);
        check("b_cnt_load", b_count, 32'hFFFFFFFF);
        tick();
        check("b_cnt_wrap", b_count, 32'h0);
        check("a_cnt_hold", a_count, 32'hFFFFFFFF);
        tick();
        check("a_cnt_wrap", a_count, 32'h0);
        mtc0(5'd9, 32'h55);
        check("b_cnt_wr_wins", b_count, 32'h55);
        tick();
        check("b_cnt_inc", b_count, 32'h56);
        check("a_cnt_ps_clr", a_count, 32'h55);

        // Hardware interrupts: B has two lines, A drives its top line.
        hw_a = 6'b100000; hw_b = 2'b10;
        tick();
        check("b_ip_byte", {24'b0, b_cause[15:8]}, 32'h08);
        check("b_cause", b_cause, 32'h00000830);
        check("b_irq", {31'b0, b_irq}, 32'h1);
        check("a_cause_hw", a_cause, 32'h00008030);
        check("a_irq_hw", {31'b0, a_irq}, 32'h1);
        hw_b = 2'b00;
        tick();
        check("b_irq_off", {31'b0, b_irq}, 32'h0);

        // Reset mid-operation beats write, exception and eret.
        rst = 1'b1; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0000FFFF;
        exc_valid_i = 1'b1; exc_code_i = 5'd4; exc_pc_i = 32'h100;
        exc_badvaddr_i = 32'h99; eret_i = 1'b1;
        tick();
        we_i = 1'b0; exc_valid_i = 1'b0; eret_i = 1'b0;
        check("mid_rst_status", a_status, 32'h10000000);
        check("mid_rst_cause", a_cause, 32'h0);
        check("mid_rst_epc", a_epc, 32'h0);
        check("mid_rst_badv", a_badv, 32'h0);
        check("mid_rst_count", a_count, 32'h0);
        check("mid_rst_irq", {30'b0, a_ti, a_irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
